// File: rtl/iir_pkg.sv
// Shared sample definitions for the IIR filter datapath and its output stages.
package iir_pkg;
    localparam int SAMPLE_W = 12;
    typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/iir_buf_ram.sv
// Register-array storage for the output buffer: one synchronous write port, one async read port.
module iir_buf_ram
    import iir_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are intentionally not reset; nothing reads them while the buffer is empty.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/iir_out_buffer.sv
// First-word-fall-through output FIFO behind IIR_filter with a valid/ready consumer port,
// fill level, sticky overflow flag and delivered-sample counter.
module iir_out_buffer
    import iir_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         DIN,
    input  logic                     VIN,
    input  logic                     READY,
    input  logic                     CLR_OVF,
    output logic [WIDTH-1:0]         DOUT,
    output logic                     VOUT,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     OVF,
    output logic [CNT_W-1:0]         SAMPLE_CNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [WIDTH-1:0] w_rdata;

    // Status is decoded only from r_level so VIN/READY never reach the outputs combinationally.
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_pop   = !w_empty && READY;
    assign w_push  = VIN && (!w_full || w_pop);
    assign w_drop  = VIN && w_full && !w_pop;

    iir_buf_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (CLK),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (DIN),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    // DEPTH is a power of two, so pointer wrap is the natural rollover of an AW-bit counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_cnt  <= r_cnt + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // A drop in the same cycle as CLR_OVF must leave the flag set.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (CLR_OVF) begin
            r_ovf <= 1'b0;
        end
    end

    assign DOUT       = w_empty ? '0 : w_rdata;
    assign VOUT       = !w_empty;
    assign FULL       = w_full;
    assign EMPTY      = w_empty;
    assign LEVEL      = r_level;
    assign OVF        = r_ovf;
    assign SAMPLE_CNT = r_cnt;

endmodule

// File: tb/tb_iir_out_buffer.sv
// Directed bench for iir_out_buffer with a queue-based reference model checked every cycle.
module tb_iir_out_buffer;

    localparam int WIDTH = 12;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             RST;
    logic [WIDTH-1:0] DIN;
    logic             VIN;
    logic             READY;
    logic             CLR_OVF;
    logic [WIDTH-1:0] DOUT;
    logic             VOUT;
    logic             FULL;
    logic             EMPTY;
    logic [3:0]       LEVEL;
    logic             OVF;
    logic [CNT_W-1:0] SAMPLE_CNT;

    int total = 0;
    int bad   = 0;

    iir_out_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DIN        (DIN),
        .VIN        (VIN),
        .READY      (READY),
        .CLR_OVF    (CLR_OVF),
        .DOUT       (DOUT),
        .VOUT       (VOUT),
        .FULL       (FULL),
        .EMPTY      (EMPTY),
        .LEVEL      (LEVEL),
        .OVF        (OVF),
        .SAMPLE_CNT (SAMPLE_CNT)
    );

    always #5 CLK = ~CLK;

    // Reference model: a plain queue plus flag and counter, updated from the handshake rules.
    logic [WIDTH-1:0] m_q[$];
    logic             m_ovf;
    int unsigned      m_cnt;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
        end else begin
            bit pop_now, full_now, push_now, drop_now;
            full_now = (m_q.size() == DEPTH);
            pop_now  = (m_q.size() > 0) && READY;
            push_now = VIN && (!full_now || pop_now);
            drop_now = VIN && full_now && !pop_now;
            if (pop_now) begin
                void'(m_q.pop_front());
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
            if (push_now) m_q.push_back(DIN);
            if (drop_now) m_ovf = 1'b1;
            else if (CLR_OVF) m_ovf = 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        int sz;
        sz = m_q.size();
        check("m_vout",  int'(VOUT),       int'(sz > 0));
        check("m_empty", int'(EMPTY),      int'(sz == 0));
        check("m_full",  int'(FULL),       int'(sz == DEPTH));
        check("m_level", int'(LEVEL),      sz);
        check("m_dout",  int'(DOUT),       (sz > 0) ? int'(m_q[0]) : 0);
        check("m_ovf",   int'(OVF),        int'(m_ovf));
        check("m_cnt",   int'(SAMPLE_CNT), int'(m_cnt));
    end

    task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic c);
        VIN = v; DIN = d; READY = r; CLR_OVF = c;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; VIN = 1'b0; DIN = '0; READY = 1'b0; CLR_OVF = 1'b0;
        #12 RST = 1'b0;
        @(posedge CLK); #1;

        check("rst_empty", int'(EMPTY), 1);
        check("rst_vout",  int'(VOUT), 0);
        check("rst_dout",  int'(DOUT), 0);
        check("rst_level", int'(LEVEL), 0);
        check("rst_ovf",   int'(OVF), 0);
        check("rst_cnt",   int'(SAMPLE_CNT), 0);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        check("idle_empty", int'(EMPTY), 1);
        check("idle_level", int'(LEVEL), 0);
        check("idle_cnt",   int'(SAMPLE_CNT), 0);

        for (int i = 1; i <= 5; i++) cyc(1'b1, 12'(i), 1'b0, 1'b0);
        check("five_level", int'(LEVEL), 5);
        for (int i = 1; i <= 5; i++) begin
            check("five_dout", int'(DOUT), i);
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        check("five_empty", int'(EMPTY), 1);
        check("five_cnt",   int'(SAMPLE_CNT), 5);

        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 12'h100 + 12'(i), 1'b0, 1'b0);
            if (i == 7) begin
                check("ovf_full8", int'(FULL), 1);
                check("ovf_pre",   int'(OVF), 0);
            end
            if (i == 8) check("ovf_set9", int'(OVF), 1);
        end
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain", int'(DOUT), 'h100 + i);
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        check("ovf_empty", int'(EMPTY), 1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("ovf_clr", int'(OVF), 0);
        check("ovf_cnt", int'(SAMPLE_CNT), 13);

        for (int i = 0; i < 8; i++) cyc(1'b1, 12'h200 + 12'(i), 1'b0, 1'b0);
        check("stream_full", int'(FULL), 1);
        for (int i = 0; i < 20; i++) begin
            check("stream_dout", int'(DOUT), 'h200 + i);
            cyc(1'b1, 12'h208 + 12'(i), 1'b1, 1'b0);
            check("stream_level", int'(LEVEL), 8);
        end
        check("stream_ovf", int'(OVF), 0);
        for (int i = 0; i < 8; i++) begin
            check("stream_drain", int'(DOUT), 'h214 + i);
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        check("stream_cnt", int'(SAMPLE_CNT), 41);

        for (int i = 0; i < 3; i++) cyc(1'b1, 12'h300 + 12'(i), 1'b0, 1'b0);
        VIN = 1'b0;
        check("prerst_level", int'(LEVEL), 3);
        #2 RST = 1'b1;
        #1;
        check("arst_vout",  int'(VOUT), 0);
        check("arst_level", int'(LEVEL), 0);
        check("arst_dout",  int'(DOUT), 0);
        #3 RST = 1'b0;
        cyc(1'b1, 12'hABC, 1'b0, 1'b0);
        check("post_vout", int'(VOUT), 1);
        check("post_dout", int'(DOUT), 'hABC);
        check("post_cnt",  int'(SAMPLE_CNT), 0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("post_empty", int'(EMPTY), 1);

        for (int i = 0; i < 8; i++) cyc(1'b1, 12'h400 + 12'(i), 1'b0, 1'b0);
        cyc(1'b1, 12'h4FF, 1'b0, 1'b1);
        check("setwins_ovf",   int'(OVF), 1);
        check("setwins_level", int'(LEVEL), 8);
        cyc(1'b0, '0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
